redmule_job_sched: RTL and testbench

Multi-core job scheduler in front of the RedMulE controller. Up to N_CORES cluster cores post job descriptors through a round-robin arbiter into a shared in-order queue. The scheduler issues one job at a time to the controller with a start/ack handshake, waits for completion, then raises a one-cycle done event to the core that owns the job. It sits between the cluster-side offload logic and the controller's start/done interface and serialises all access to the single engine.

---
 rtl/redmule_job_sched_pkg.sv | 24 ++
 rtl/redmule_job_fifo.sv | 71 +++++++
 rtl/redmule_job_sched.sv | 164 ++++++++++++++++
 tb/tb_redmule_job_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_job_sched_pkg.sv
// Shared types for the RedMulE job scheduler: FSM state encoding and queue entry layout.
package redmule_job_sched_pkg;

  function automatic int core_id_w(input int n_cores);
    return (n_cores > 1) ? $clog2(n_cores) : 1;
  endfunction

  localparam int DefNCores   = 8;
  localparam int DefJobWidth = 32;
  localparam int DefCoreIdW  = core_id_w(DefNCores);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    NOTIFY
  } sched_state_e;

  typedef struct packed {
    logic [DefCoreIdW-1:0]  core_id;
    logic [DefJobWidth-1:0] job;
  } sched_entry_t;

endpackage

// File: rtl/redmule_job_fifo.sv
// Generic synchronous FIFO with soft clear; full/empty are registered from the next count.
module redmule_job_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CntW-1:0]   count_o
);

  localparam int AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_q && !clear_i;
  assign do_pop  = pop_i && !empty_q && !clear_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CntW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage carries data only, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/redmule_job_sched.sv
// Round-robin multi-core job scheduler serialising access to the RedMulE controller.
// Optional watchdog abort enabled by defining REDMULE_JOB_SCHED_WATCHDOG_EN.
module redmule_job_sched
  import redmule_job_sched_pkg::*;
#(
  parameter int N_CORES       = DefNCores,
  parameter int QUEUE_DEPTH   = 4,
  parameter int JobWidth      = DefJobWidth,
  parameter int TimeoutCycles = 65536,
  localparam int CoreIdW      = core_id_w(N_CORES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [N_CORES-1:0]          req_i,
  input  logic [N_CORES*JobWidth-1:0] job_i,
  output logic [N_CORES-1:0]          gnt_o,
  output logic                        start_o,
  input  logic                        start_ack_i,
  output logic [JobWidth-1:0]         job_o,
  output logic [CoreIdW-1:0]          core_id_o,
  input  logic                        done_i,
  output logic [N_CORES-1:0]          evt_o,
  output logic                        timeout_o,
  output logic                        busy_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int CntW   = $clog2(QUEUE_DEPTH + 1);
  localparam int EntryW = CoreIdW + JobWidth;
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);

  sched_state_e        state_q;
  logic [CoreIdW-1:0]  rr_q, core_q, gnt_idx, rr_next;
  logic [JobWidth-1:0] job_q, gnt_job;
  logic [N_CORES-1:0]  gnt, evt_q;
  logic                start_q, found, fifo_pop, fifo_full, fifo_empty, wd_hit;
  logic [CntW-1:0]     fifo_cnt;
  logic [EntryW-1:0]   push_data, head;

  // Two passes: first requesters at or above the pointer, then wrap to the low indices.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_job = '0;
    found   = 1'b0;
    if (!clear_i && (fifo_cnt < DepthCnt)) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (!found && req_i[i] && (CoreIdW'(i) >= rr_q)) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = CoreIdW'(i);
          gnt_job = job_i[i*JobWidth +: JobWidth];
        end
      end
      for (int i = 0; i < N_CORES; i++) begin
        if (!found && req_i[i]) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = CoreIdW'(i);
          gnt_job = job_i[i*JobWidth +: JobWidth];
        end
      end
    end
  end

  assign rr_next   = (gnt_idx == CoreIdW'(N_CORES - 1)) ? '0 : gnt_idx + 1'b1;
  assign push_data = {gnt_idx, gnt_job};
  assign fifo_pop  = (state_q == IDLE) && (fifo_cnt != '0) && !clear_i;

  redmule_job_fifo #(
    .DATA_W(EntryW),
    .DEPTH (QUEUE_DEPTH)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear_i),
    .push_i (found),
    .data_i (push_data),
    .pop_i  (fifo_pop),
    .data_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );

`ifdef REDMULE_JOB_SCHED_WATCHDOG_EN
  localparam int WdW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);
  logic [WdW-1:0] wd_q;
  // A completion arriving on the last watchdog cycle takes precedence over the abort.
  assign wd_hit = (state_q == RUN) && (wd_q == WdLast) && !done_i && !clear_i;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles > 0);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      job_q   <= '0;
      core_q  <= '0;
      start_q <= 1'b0;
      evt_q   <= '0;
`ifdef REDMULE_JOB_SCHED_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else if (clear_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      start_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      if (found) rr_q <= rr_next;
      evt_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (fifo_cnt != '0) begin
            job_q   <= head[JobWidth-1:0];
            core_q  <= head[EntryW-1 -: CoreIdW];
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (start_ack_i) begin
            start_q <= 1'b0;
            state_q <= RUN;
`ifdef REDMULE_JOB_SCHED_WATCHDOG_EN
            wd_q    <= '0;
`endif
          end
        end
        RUN: begin
          if (done_i || wd_hit) begin
            evt_q[core_q] <= 1'b1;
            state_q       <= NOTIFY;
          end
`ifdef REDMULE_JOB_SCHED_WATCHDOG_EN
          else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        NOTIFY:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o     = gnt;
  assign start_o   = start_q;
  assign job_o     = job_q;
  assign core_id_o = core_q;
  assign evt_o     = evt_q;
  assign timeout_o = wd_hit;
  assign busy_o    = (state_q != IDLE) || (fifo_cnt != '0);
  assign full_o    = fifo_full;
  assign empty_o   = fifo_empty;

endmodule

// File: tb/tb_redmule_job_sched.sv
// Scoreboard bench for redmule_job_sched: expected jobs are queued as requests are driven
// and compared against job_o/core_id_o when start_o rises.
`timescale 1ns/1ps
module tb_redmule_job_sched;
  import redmule_job_sched_pkg::*;

  localparam int NC = 8;
  localparam int JW = 32;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           rst_i, clear_i;
  logic [NC-1:0]  req_i;
  logic [NC*JW-1:0] job_i;
  logic [NC-1:0]  gnt_o;
  logic           start_o, start_ack_i, done_i;
  logic [JW-1:0]  job_o;
  logic [CW-1:0]  core_id_o;
  logic [NC-1:0]  evt_o;
  logic           timeout_o, busy_o, full_o, empty_o;

  logic man_ack = 1'b0, man_done = 1'b0, auto_ctrl = 1'b0, auto_done = 1'b0;
  int   n_checks = 0, n_err = 0;
  sched_entry_t sb[$];
  sched_entry_t mon_e;
  logic [CW-1:0] last_core = '0;
  logic          start_prev = 1'b0;
  logic [NC-1:0] evt_prev = '0;
  logic          fair_mode = 1'b0;
  int            g_idx = 0;
  logic [NC-1:0] pend;

  redmule_job_sched #(
    .N_CORES      (NC),
    .QUEUE_DEPTH  (4),
    .JobWidth     (JW),
    .TimeoutCycles(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .req_i      (req_i),
    .job_i      (job_i),
    .gnt_o      (gnt_o),
    .start_o    (start_o),
    .start_ack_i(start_ack_i),
    .job_o      (job_o),
    .core_id_o  (core_id_o),
    .done_i     (done_i),
    .evt_o      (evt_o),
    .timeout_o  (timeout_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  always #5 clk = ~clk;

  // Auto controller: ack immediately, complete in the following cycle.
  assign start_ack_i = auto_ctrl ? start_o : man_ack;
  assign done_i      = auto_ctrl ? auto_done : man_done;
  always @(posedge clk) auto_done <= auto_ctrl && start_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!start_o && n < 40) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(start_o), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (busy_o && n < 300) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(busy_o), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic serve(input logic [NC-1:0] exp_evt);
    man_ack = 1'b1;
    tick();
    man_ack  = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("serve_evt", 32'(evt_o), 32'(exp_evt));
    tick();
    chk("serve_evt_clr", 32'(evt_o), 32'd0);
  endtask

  task automatic add_job(input int core, input logic [JW-1:0] job);
    job_i[core*JW +: JW] = job;
    sb.push_back(sched_entry_t'{core_id: CW'(core), job: job});
  endtask

  // Monitor: scoreboard pop on start_o rise, owner check on evt_o, grant order in fairness run.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (start_o && !start_prev) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("job_o", job_o, mon_e.job);
          chk("core_id_o", 32'(core_id_o), 32'(mon_e.core_id));
          last_core = mon_e.core_id;
        end
      end
      if (evt_o != '0) begin
        chk("evt_owner", 32'(evt_o), 32'(8'h01 << last_core));
        chk("evt_one_cycle", 32'(evt_prev), 32'd0);
      end
      if (fair_mode && gnt_o != '0) begin
        chk("gnt_order", 32'(gnt_o), (g_idx < NC) ? (32'd1 << g_idx) : 32'd0);
        g_idx++;
      end
    end
    start_prev = start_o;
    evt_prev   = evt_o;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_i = '0; job_i = '0;
    #2;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_job", job_o, 32'd0);
    chk("rst_core", 32'(core_id_o), 32'd0);
    chk("rst_evt", 32'(evt_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    tick();

    // Fairness: all cores request at once, each must be granted exactly once in order 0..7.
    for (int i = 0; i < NC; i++) add_job(i, 32'h0000_0100 + 32'(i));
    fair_mode = 1'b1;
    auto_ctrl = 1'b1;
    pend = '1;
    for (int c = 0; c < 300; c++) begin
      req_i = pend;
      #1;
      pend = pend & ~gnt_o;
      if (pend == '0 && !busy_o) break;
      tick();
    end
    req_i = '0;
    fair_mode = 1'b0;
    chk("fair_grants", 32'(g_idx), 32'd8);
    chk("fair_idle", 32'(busy_o), 32'd0);
    chk("sb_left", 32'(sb.size()), 32'd0);
    tick();
    auto_ctrl = 1'b0;
    tick();

    // Single job: exact cycle timing from request to done event.
    add_job(2, 32'hCAFE_0000);
    req_i = 8'h04;
    #1 chk("single_gnt", 32'(gnt_o), 32'h04);
    tick();
    req_i = '0;
    chk("single_c1_start", 32'(start_o), 32'd0);
    chk("single_c1_empty", 32'(empty_o), 32'd0);
    chk("single_c1_busy", 32'(busy_o), 32'd1);
    tick();
    chk("single_c2_start", 32'(start_o), 32'd1);
    chk("single_c2_job", job_o, 32'hCAFE_0000);
    chk("single_c2_core", 32'(core_id_o), 32'd2);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("single_run_start", 32'(start_o), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("single_evt", 32'(evt_o), 32'h04);
    tick();
    chk("single_evt_clr", 32'(evt_o), 32'd0);
    chk("single_idle", 32'(busy_o), 32'd0);

    // Full queue: engine held in RUN while four more jobs queue up.
    add_job(3, 32'h3000_0003);
    req_i = 8'h08;
    tick();
    req_i = '0;
    wait_start();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    for (int i = 4; i < NC; i++) add_job(i, 32'h4000_0000 + 32'(i));
    pend = 8'hF0;
    for (int c = 0; c < 10 && pend != '0; c++) begin
      req_i = pend;
      #1;
      pend = pend & ~gnt_o;
      tick();
    end
    req_i = 8'h01;
    job_i[0 +: JW] = 32'h0A0A_0000;
    #1;
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_no_gnt", 32'(gnt_o), 32'd0);
    tick();
    chk("full_no_gnt2", 32'(gnt_o), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("full_notify_gnt", 32'(gnt_o), 32'd0);
    tick();
    chk("full_pop_gnt", 32'(gnt_o), 32'd0);
    chk("full_pop_flag", 32'(full_o), 32'd1);
    tick();
    chk("full_after_pop", 32'(full_o), 32'd0);
    chk("full_regnt", 32'(gnt_o), 32'h01);
    sb.push_back(sched_entry_t'{core_id: 3'd0, job: 32'h0A0A_0000});
    tick();
    req_i = '0;
    auto_ctrl = 1'b1;
    drain();
    tick();
    auto_ctrl = 1'b0;
    tick();

    // Spurious handshakes: done_i while in ISSUE, start_ack_i while in RUN.
    add_job(1, 32'h1111_0001);
    req_i = 8'h02;
    tick();
    req_i = '0;
    wait_start();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("spur_issue_hold", 32'(start_o), 32'd1);
    chk("spur_issue_evt", 32'(evt_o), 32'd0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("spur_run_start", 32'(start_o), 32'd0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("spur_run_evt", 32'(evt_o), 32'd0);
    chk("spur_run_busy", 32'(busy_o), 32'd1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("spur_evt", 32'(evt_o), 32'h02);
    tick();
    chk("spur_evt_clr", 32'(evt_o), 32'd0);

    // Soft clear while running with two queued; done_i in the same cycle must not notify.
    add_job(5, 32'h5555_0005);
    req_i = 8'h20;
    tick();
    req_i = '0;
    wait_start();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    pend = 8'h06;
    for (int c = 0; c < 10 && pend != '0; c++) begin
      req_i = pend;
      #1;
      pend = pend & ~gnt_o;
      tick();
    end
    req_i = '0;
    chk("clr_pre_empty", 32'(empty_o), 32'd0);
    clear_i  = 1'b1;
    man_done = 1'b1;
    #1;
    chk("clr_same_timeout", 32'(timeout_o), 32'd0);
    tick();
    clear_i  = 1'b0;
    man_done = 1'b0;
    chk("clr_empty", 32'(empty_o), 32'd1);
    chk("clr_busy", 32'(busy_o), 32'd0);
    chk("clr_start", 32'(start_o), 32'd0);
    chk("clr_evt", 32'(evt_o), 32'd0);
    tick();
    chk("clr_evt2", 32'(evt_o), 32'd0);
    add_job(7, 32'h8000_0007);
    req_i = 8'h80;
    #1 chk("clr_first_gnt", 32'(gnt_o), 32'h80);
    tick();
    req_i = '0;
    wait_start();
    serve(8'h80);

    // Watchdog behaviour (or its absence in the default build).
    add_job(6, 32'h6666_0006);
    req_i = 8'h40;
    tick();
    req_i = '0;
    wait_start();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
`ifdef REDMULE_JOB_SCHED_WATCHDOG_EN
    for (int r = 0; r < 15; r++) begin
      chk("wd_quiet", 32'(timeout_o), 32'd0);
      tick();
    end
    chk("wd_fire", 32'(timeout_o), 32'd1);
    chk("wd_fire_evt", 32'(evt_o), 32'd0);
    tick();
    chk("wd_evt", 32'(evt_o), 32'h40);
    chk("wd_pulse", 32'(timeout_o), 32'd0);
    tick();
    add_job(6, 32'h6666_0106);
    req_i = 8'h40;
    tick();
    req_i = '0;
    wait_start();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    repeat (15) tick();
    man_done = 1'b1;
    #1 chk("wd_done_wins", 32'(timeout_o), 32'd0);
    tick();
    man_done = 1'b0;
    chk("wd_done_evt", 32'(evt_o), 32'h40);
    chk("wd_done_no_to", 32'(timeout_o), 32'd0);
    tick();
`else
    for (int r = 0; r < 20; r++) begin
      chk("nowd_quiet", 32'(timeout_o), 32'd0);
      tick();
    end
    chk("nowd_no_evt", 32'(evt_o), 32'd0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("nowd_evt", 32'(evt_o), 32'h40);
    tick();
`endif
    chk("final_idle", 32'(busy_o), 32'd0);
    chk("final_sb", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
